// File: rtl/sub_pkg.sv
// Shared definitions for the pipelined borrow-lookahead subtractor.
//   GROUP_W         : width of one borrow-lookahead group (fixed at 4)
//   group_payload_t : per-group slice of a stage payload; diff holds resolved difference bits,
//                     a_rem/b_rem hold operand bits not yet resolved
//   width_ok()      : elaboration-time check of the WIDTH / GROUPS_PER_STAGE combination
package sub_pkg;

   localparam int unsigned GROUP_W = 4;

   typedef struct packed {
      logic [GROUP_W-1:0] diff;
      logic [GROUP_W-1:0] a_rem;
      logic [GROUP_W-1:0] b_rem;
   } group_payload_t;

   function automatic bit width_ok(input int unsigned width, input int unsigned gps);
      return (width != 0) && (gps != 0) && (width % GROUP_W == 0) &&
             (width % (GROUP_W * gps) == 0);
   endfunction

endpackage

// File: rtl/borrow_lookahead_group_4.sv
// One 4-bit borrow-lookahead group.
//   a_i, b_i     : operand nibbles (minuend, subtrahend)
//   bin_i        : borrow into the group
//   d_o          : difference nibble
//   group_gen_o  : group generates a borrow regardless of bin_i
//   group_prop_o : group passes bin_i through to its borrow out
module borrow_lookahead_group_4
   import sub_pkg::*;
(
   input  logic [GROUP_W-1:0] a_i,
   input  logic [GROUP_W-1:0] b_i,
   input  logic               bin_i,
   output logic [GROUP_W-1:0] d_o,
   output logic               group_gen_o,
   output logic               group_prop_o
);

   logic [3:0] gen;
   logic [3:0] prop;
   logic [3:0] borrow;

   assign gen  = ~a_i & b_i;
   assign prop = ~(a_i ^ b_i);

   // Flattened lookahead: every bit borrow comes straight from bin_i, no ripple.
   assign borrow[0] = bin_i;
   assign borrow[1] = gen[0] | (prop[0] & bin_i);
   assign borrow[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & bin_i);
   assign borrow[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0]) |
                      (&prop[2:0] & bin_i);

   assign d_o = a_i ^ b_i ^ borrow;

   assign group_gen_o  = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1]) |
                         (&prop[3:1] & gen[0]);
   assign group_prop_o = &prop;

endmodule

// File: rtl/pipelined_borrow_lookahead_subtractor.sv
// Pipelined unsigned subtractor: out_diff_o = in_a_i - in_b_i - in_bin_i (mod 2^WIDTH).
// Each stage resolves GROUPS_PER_STAGE 4-bit groups and registers the result; STAGES stages.
// Ports:
//   clk, rst_n                : clock (rising edge), asynchronous active-low reset
//   in_valid_i / in_ready_o   : input handshake
//   in_a_i, in_b_i, in_bin_i  : minuend, subtrahend, borrow in
//   out_valid_o / out_ready_i : output handshake
//   out_diff_o, out_bout_o    : difference, borrow out (1 = underflow)
//   out_sat_o                 : saturation applied
// Build option: define SUB_SATURATE_EN to clamp underflowing results to 0 and raise out_sat_o;
// otherwise the result wraps and out_sat_o is tied 0.
module pipelined_borrow_lookahead_subtractor
   import sub_pkg::*;
#(
   parameter int unsigned WIDTH            = 16,
   parameter int unsigned GROUPS_PER_STAGE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic             in_bin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_diff_o,
   output logic             out_bout_o,
   output logic             out_sat_o
);

   localparam int unsigned NGROUPS = WIDTH / GROUP_W;
   localparam int unsigned STAGES  = WIDTH / (GROUP_W * GROUPS_PER_STAGE);

   if (!width_ok(WIDTH, GROUPS_PER_STAGE)) begin : g_bad_width
      $error("WIDTH must be a nonzero multiple of 4*GROUPS_PER_STAGE");
   end

   group_payload_t [NGROUPS-1:0] pay_in [STAGES];
   group_payload_t [NGROUPS-1:0] pay_d  [STAGES];
   group_payload_t [NGROUPS-1:0] pay_q  [STAGES];

   logic [STAGES-1:0]  valid_in, valid_q;
   logic [STAGES-1:0]  borrow_in, borrow_d, borrow_q;
   logic [STAGES-1:0]  load, advance;
   logic [NGROUPS-1:0] grp_gen, grp_prop, grp_bin, grp_bout;
   logic [GROUP_W-1:0] grp_d [NGROUPS];

   // Stage inputs: stage 0 from the ports, later stages from the previous register.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
      if (k == 0) begin : g_first
         assign valid_in[0]  = in_valid_i;
         assign borrow_in[0] = in_bin_i;
         for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
            assign pay_in[0][g] = '{diff:  '0,
                                    a_rem: in_a_i[g*GROUP_W +: GROUP_W],
                                    b_rem: in_b_i[g*GROUP_W +: GROUP_W]};
         end
      end else begin : g_rest
         assign valid_in[k]  = valid_q[k-1];
         assign borrow_in[k] = borrow_q[k-1];
         assign pay_in[k]    = pay_q[k-1];
      end
   end

   // One group instance per nibble; it works on the stage that owns it.
   for (genvar g = 0; g < NGROUPS; g++) begin : g_group
      localparam int unsigned S = g / GROUPS_PER_STAGE;

      if (g % GROUPS_PER_STAGE == 0) begin : g_head
         assign grp_bin[g] = borrow_in[S];
      end else begin : g_chain
         assign grp_bin[g] = grp_bout[g-1];
      end

      borrow_lookahead_group_4 u_group (
         .a_i          (pay_in[S][g].a_rem),
         .b_i          (pay_in[S][g].b_rem),
         .bin_i        (grp_bin[g]),
         .d_o          (grp_d[g]),
         .group_gen_o  (grp_gen[g]),
         .group_prop_o (grp_prop[g])
      );

      assign grp_bout[g] = grp_gen[g] | (grp_prop[g] & grp_bin[g]);
   end

   // Next payload: the owned slice becomes resolved, everything else passes through.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage_d
      assign borrow_d[k] = grp_bout[(k+1)*GROUPS_PER_STAGE-1];
      for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
         if (g / GROUPS_PER_STAGE == k) begin : g_own
            assign pay_d[k][g] = '{diff: grp_d[g], a_rem: '0, b_rem: '0};
         end else begin : g_pass
            assign pay_d[k][g] = pay_in[k][g];
         end
      end
   end

   // Ready chain: a stage loads when empty or when its contents move on this cycle.
   assign advance[STAGES-1] = out_ready_i;
   for (genvar k = 0; k < STAGES; k++) begin : g_hs
      if (k < STAGES - 1) begin : g_mid
         assign advance[k] = load[k+1];
      end
      assign load[k] = !valid_q[k] || advance[k];
   end
   assign in_ready_o = load[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         borrow_q <= '0;
         for (int unsigned k = 0; k < STAGES; k++) pay_q[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               valid_q[k] <= valid_in[k];
               // Data only moves with a real beat, so an idle stage keeps its last value.
               if (valid_in[k]) begin
                  pay_q[k]    <= pay_d[k];
                  borrow_q[k] <= borrow_d[k];
               end
            end
         end
      end
   end

   logic [WIDTH-1:0]   diff_w;
   logic [NGROUPS-1:0] unused_rem;
   for (genvar g = 0; g < NGROUPS; g++) begin : g_out
      assign diff_w[g*GROUP_W +: GROUP_W] = pay_q[STAGES-1][g].diff;
      assign unused_rem[g] = ^{pay_q[STAGES-1][g].a_rem, pay_q[STAGES-1][g].b_rem};
   end

   assign out_valid_o = valid_q[STAGES-1];
   assign out_bout_o  = borrow_q[STAGES-1];

`ifdef SUB_SATURATE_EN
   assign out_diff_o = borrow_q[STAGES-1] ? '0 : diff_w;
   assign out_sat_o  = borrow_q[STAGES-1];
`else
   assign out_diff_o = diff_w;
   assign out_sat_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_borrow_lookahead_subtractor.sv
// Self-checking bench for pipelined_borrow_lookahead_subtractor (WIDTH=16, 2 groups/stage).
module tb_pipelined_borrow_lookahead_subtractor;

   localparam int W      = 16;
   localparam int STAGES = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_diff;
   logic         out_bout;
   logic         out_sat;

   pipelined_borrow_lookahead_subtractor #(
      .WIDTH            (W),
      .GROUPS_PER_STAGE (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_bin_i    (in_bin),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_diff_o  (out_diff),
      .out_bout_o  (out_bout),
      .out_sat_o   (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         sat;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   exp_t sb[$];
   int   pop_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic [W-1:0] d, input logic bo);
      exp_t e;
      e.diff = d;
      e.bout = bo;
      e.sat  = 1'b0;
`ifdef SUB_SATURATE_EN
      if (bo) begin
         e.diff = '0;
         e.sat  = 1'b1;
      end
`endif
      return e;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bin);
      logic [W:0] r;
      r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      return mk(r[W-1:0], r[W]);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard consumer: a transfer happens on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got diff=0x%0h bout=%0b, none expected",
                     out_diff, out_bout);
         end else begin
            exp_t e;
            e = sb.pop_front();
            pop_cyc.push_back(cyc);
            if ({out_diff, out_bout, out_sat} !== e) begin
               n_bad++;
               $display("FAIL result: got diff=0x%0h bout=%0b sat=%0b, expected diff=0x%0h bout=%0b sat=%0b",
                        out_diff, out_bout, out_sat, e.diff, e.bout, e.sat);
            end
         end
      end
   end

   // Presents one beat (in_valid stays high afterwards) and returns just after acceptance.
   task automatic send_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                           input exp_t e);
      int w;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_bin   = bin;
      w        = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", w);
      end else begin
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      send_exp(a, b, bin, model(a, b, bin));
   endtask

   task automatic drain();
      int w;
      in_valid = 1'b0;
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(posedge clk);
         #1;
         w++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk("drain_left", sb.size(), 0);
   endtask

   vec_t vecs[10];
   int   lat;
   int   idx;
   exp_t e0;
   logic acc;

   initial begin
      vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0};
      vecs[1] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
      vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1};
      vecs[3] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
      vecs[6] = '{16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0};
      vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
      vecs[8] = '{16'h00FF, 16'h0100, 1'b0, 16'hFFFF, 1'b1};
      vecs[9] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_diff", out_diff, 0);
      chk("rst_out_bout", out_bout, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency from an empty pipeline
      chk("lat_in_ready", in_ready, 1);
      sb.push_back(mk(16'h1200, 1'b0));
      in_valid = 1'b1;
      in_a     = 16'h1234;
      in_b     = 16'h0034;
      in_bin   = 1'b0;
      lat      = 0;
      do begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      chk("latency", lat, STAGES);
      drain();

      // Table vectors, streamed back to back
      for (int i = 0; i < 10; i++) begin
         send_exp(vecs[i].a, vecs[i].b, vecs[i].bin, mk(vecs[i].diff, vecs[i].bout));
      end
      drain();

      // Eight back-to-back beats must come out on consecutive cycles
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'(i * 16'h1111);
         b = W'(i);
         send(a, b, 1'b0);
      end
      drain();
      chk("burst_count", pop_cyc.size(), 8);
      for (int i = 1; i < 8 && i < pop_cyc.size(); i++) begin
         chk("burst_gap", pop_cyc[i] - pop_cyc[i-1], 1);
      end

      // Backpressure: out_ready low for 5 cycles while the source keeps pushing
      out_ready = 1'b0;
      idx       = 0;
      e0        = model(16'h4000, 16'h0000, 1'b0);
      in_valid  = 1'b1;
      in_a      = 16'h4000;
      in_b      = 16'h0000;
      in_bin    = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) sb.push_back(model(in_a, in_b, in_bin));
         if (c >= 2) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_held_diff", {out_diff, out_bout, out_sat}, e0);
         end
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            in_a   = W'(16'h4000 + idx * 16'h0101);
            in_b   = W'(idx * 3);
            in_bin = idx[0];
         end
      end
      chk("bp_accepted", idx, 2);
      chk("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      for (int i = idx; i < 6; i++) begin
         send(W'(16'h4000 + i * 16'h0101), W'(i * 3), i[0]);
      end
      drain();

      // Asynchronous reset with two beats in flight
      send(16'h1111, 16'h0001, 1'b0);
      send(16'h2222, 16'h0002, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_diff", out_diff, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_exp(16'h0010, 16'h0001, 1'b0, mk(16'h000F, 1'b0));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
